ifu_fetch_queue: RTL

Parametrised next-generation instruction fetch unit. It decouples PC generation from decode with a QDEPTH-entry in-order prefetch queue. Up to QDEPTH cache reads can be in flight at once. Branch/exception redirects flush the queue and discard stale responses. It sits between the branch/CSR redirect logic, the I-cache read port and the ID stage.

---
 rtl/ifu_fetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: issues sequential I-cache reads into an in-order prefetch
// queue, hands filled entries to decode, and flushes on redirect.
module ifu_fetch_queue #(
    parameter int                XLEN     = 64,
    parameter int                ILEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(64'h0000_0000_8000_0000),
    parameter int                QDEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    input  logic                      fetch_hold,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [XLEN-1:0]           req_addr,
    input  logic                      resp_valid,
    input  logic [ILEN-1:0]           resp_data,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [XLEN+ILEN-1:0]      id_bus,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]   r_fpc;
    logic [XLEN-1:0]   r_slot_pc   [QDEPTH];
    logic [ILEN-1:0]   r_slot_inst [QDEPTH];
    logic [QDEPTH-1:0] r_slot_filled;
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_alloc;
    logic [AW-1:0]     r_fill;
    logic [CW-1:0]     r_count;
    // Reserved-but-unfilled slots; alloc-fill alone cannot tell empty from full.
    logic [CW-1:0]     r_pend;
    logic [CW-1:0]     r_drop;

    logic              w_req_fire;
    logic              w_deq;
    logic              w_fill;
    logic              w_discard;
    logic [QDEPTH-1:0] w_alloc_sel;
    logic [QDEPTH-1:0] w_fill_sel;
    logic [QDEPTH-1:0] w_deq_sel;

    assign req_valid = rst_n & ~fetch_hold & ~redirect_valid & (r_count < CW'(QDEPTH));
    assign req_addr  = r_fpc;
    assign id_valid  = r_slot_filled[r_head] & (r_count != '0) & ~redirect_valid;
    assign id_bus    = {r_slot_pc[r_head], r_slot_inst[r_head]};
    assign q_count   = r_count;

    assign w_req_fire = req_valid & req_ready;
    assign w_deq      = id_valid & id_ready;
    assign w_fill     = resp_valid & (r_drop == '0);
    assign w_discard  = resp_valid & (r_drop != '0);

    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_sel
        assign w_alloc_sel[gi] = w_req_fire & (r_alloc == AW'(gi));
        assign w_fill_sel[gi]  = w_fill     & (r_fill  == AW'(gi));
        assign w_deq_sel[gi]   = w_deq      & (r_head  == AW'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_slot_pc[i]   <= '0;
                r_slot_inst[i] <= '0;
            end
            r_slot_filled <= '0;
        end else if (redirect_valid) begin
            r_slot_filled <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (w_alloc_sel[i]) r_slot_pc[i]   <= r_fpc;
                if (w_fill_sel[i])  r_slot_inst[i] <= resp_data;
            end
            r_slot_filled <= (r_slot_filled & ~w_deq_sel & ~w_alloc_sel) | w_fill_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc   <= RESET_PC;
            r_head  <= '0;
            r_alloc <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_pend  <= '0;
            r_drop  <= '0;
        end else if (redirect_valid) begin
            r_fpc   <= redirect_pc;
            r_head  <= '0;
            r_alloc <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_pend  <= '0;
            // Every read still in flight must be swallowed, minus the one arriving now.
            r_drop  <= r_drop + r_pend - CW'(resp_valid);
        end else begin
            if (w_req_fire) begin
                r_fpc   <= r_fpc + XLEN'(4);
                r_alloc <= r_alloc + AW'(1);
            end
            if (w_fill) r_fill <= r_fill + AW'(1);
            if (w_deq)  r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_req_fire) - CW'(w_deq);
            r_pend  <= r_pend  + CW'(w_req_fire) - CW'(w_fill);
            r_drop  <= r_drop  - CW'(w_discard);
        end
    end

endmodule
